player_ctrl_multi: RTL and testbench
====================================

# player_ctrl_multi

Parametrised player controller for the lane-crossing game. It moves the player sprite on a grid from four direction switches, with rate limiting, and tests the player against up to NUM_CARS car rectangles. It keeps a saturating BCD score of SCORE_DIGITS digits and drives active-low 7-segment digits. It sits between the car generators and the VGA sprite renderer.

## Interface
- H_DISPLAY, 640: visible width (px)
- V_DISPLAY, 480: visible height (px)
- PLAYER_WIDTH / PLAYER_HEIGHT, 32 / 32: player box
- STEP, 32: pixels per move
- MOVE_PERIOD, 5000000: minimum clocks between moves, ≥2
- NUM_CARS, 8: car channels, 1..16
- CAR_WIDTH / CAR_HEIGHT, 64 / 32: car box
- SCORE_DIGITS, 2: BCD digits, 1..4
- LIVES, 3: starting lives, 1..15 (PLAYER_LIVES_EN only)
- HIT_HOLD, 25000000: clocks the player is frozen after a hit, ≥1

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- SW1 / SW2 / SW3 / SW4  in  1 each  up / down / left / right, level
- car_x  in  NUM_CARS*10  packed car x, car i at [10i+9:10i]
- car_y  in  NUM_CARS*10  packed car y
- car_active  in  NUM_CARS  per-car collision enable
- rplayer_x, rplayer_y  out  10 each  player top-left
- score_bcd  out  SCORE_DIGITS*4  score, digit 0 = units
- seg  out  SCORE_DIGITS*7  {A..G} per digit, active-low, digit 0 in LSBs
- lives  out  4  remaining lives
- hit_pulse, score_pulse  out  1  one-cycle event strobes
- game_over  out  1  game-over flag

## Operation
- States: PLAY, HIT, GAME_OVER.
- Reset values:
  - rplayer_x = H_DISPLAY/2, rplayer_y = V_DISPLAY-PLAYER_HEIGHT (the spawn point)
  - score 0; each seg digit 7'b0000001
  - lives = LIVES
  - all pulses 0, game_over 0, state PLAY
  - move-ready flag set
- Move timer: counts to MOVE_PERIOD-1, then holds and sets ready. A move clears ready and restarts the count. The first press after idle therefore moves immediately; a held switch repeats every MOVE_PERIOD clocks.
- Move rules (PLAY with ready only):
  - Priority is up > down > left > right.
  - A step happens only if the result stays within [0, H_DISPLAY-PLAYER_WIDTH] × [0, V_DISPLAY-PLAYER_HEIGHT]. A blocked direction does not consume ready and does not fall through to a lower-priority direction.
- Collision: car i hits when car_active[i] and the boxes overlap with strict inequalities. All sums use 11-bit arithmetic, so there is no 10-bit wrap. The result is the OR over all cars, evaluated on the registered position in PLAY only.
- Hit in PLAY:
  - hit_pulse fires, state goes to HIT, and the player is frozen for HIT_HOLD clocks.
  - The player then respawns, ready is cleared, the timer restarts, and the state returns to PLAY (or to GAME_OVER, see Configuration).
- Goal: rplayer_y == 0 in PLAY and no hit on the same cycle. Score increments (BCD, saturating at all nines), score_pulse fires, and the player respawns.
- Simultaneous hit and goal: the hit wins and score is unchanged.
- All four switches high: soft reset, identical to RST, from any state.

## Timing
- Switch sampled at edge N with ready set → new position visible after edge N.
- Overlap at cycle N → hit_pulse high during cycle N+1, lives updated in the same cycle.
- Respawn: position is written at the end of the HIT_HOLD-th HIT cycle.
- score_bcd updates 1 cycle after the goal is detected; seg follows score_bcd one cycle later (registered decode).
- Car inputs are treated as synchronous to CLK. No input registering is required.

## Configuration
- PLAYER_LIVES_EN defined:
  - A hit decrements lives and keeps the score.
  - A hit at lives==1 sets lives 0, and HIT exits to GAME_OVER.
  - In GAME_OVER: game_over=1, the player stays at spawn, and only the soft reset or RST leaves.
- PLAYER_LIVES_EN undefined:
  - A hit clears the score.
  - lives is a constant 0, game_over a constant 0, and GAME_OVER is unreachable.

## Structure
- Package player_pkg holds:
  - the state enum
  - COORD_W=10 and the 11-bit compare width
  - the 7-segment encoding function (0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, invalid→0011000)
- Sub-module bcd_score_counter: parameter SCORE_DIGITS; inputs inc and clr; saturating ripple-carry BCD.

## Test plan
- Reset, then SW1 held 3×MOVE_PERIOD (MOVE_PERIOD=4 in bench) → rplayer_y 448→416→384→352, first step on the cycle after the press.
- Player at x=0, SW3 plus SW4 held → no move (left wins priority and is blocked); x stays 0 and ready stays 1.
- car_x[0]=320, car_y[0]=416, car_active=1, player steps to y=416 → hit_pulse on the next cycle, lives 3→2, respawn at (320,448) after HIT_HOLD.
- Same overlap with car_active[0]=0 → no hit_pulse.
- Reach y=0 ten times → score_bcd=8'h10, seg digit1=1001111 and digit0=0000001; with the score preloaded to 99, one more goal → stays 99.
- With PLAYER_LIVES_EN, three hits → game_over=1 and SW1..SW4 ignored; all four switches high → score 0, lives 3, state PLAY.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and helpers for the lane-crossing player controller.
package player_pkg;

  localparam int COORD_W = 10;
  localparam int CMP_W   = 11;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HIT       = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  // Active-low {A..G} pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0011000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating ripple-carry BCD counter; holds at all nines, clr wins over inc.
module bcd_score_counter #(
  parameter int SCORE_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [SCORE_DIGITS*4-1:0] score_bcd
);

  logic [SCORE_DIGITS*4-1:0] next_bcd;
  logic                      all_nines;
  logic                      carry;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_bcd  = score_bcd;
    all_nines = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++)
      if (score_bcd[4*i +: 4] != 4'd9) all_nines = 1'b0;
    carry = inc & ~all_nines;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          next_bcd[4*i +: 4] = 4'd0;
        end else begin
          next_bcd[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clr) score_bcd <= '0;
    else            score_bcd <= next_bcd;
  end

endmodule

// File: rtl/player_ctrl_multi.sv
// Player movement, multi-car collision, BCD score and 7-segment output.
// Optional lives / game-over behaviour is enabled by defining PLAYER_LIVES_EN.
module player_ctrl_multi
  import player_pkg::*;
#(
  parameter int H_DISPLAY     = 640,
  parameter int V_DISPLAY     = 480,
  parameter int PLAYER_WIDTH  = 32,
  parameter int PLAYER_HEIGHT = 32,
  parameter int STEP          = 32,
  parameter int MOVE_PERIOD   = 5000000,
  parameter int NUM_CARS      = 8,
  parameter int CAR_WIDTH     = 64,
  parameter int CAR_HEIGHT    = 32,
  parameter int SCORE_DIGITS  = 2,
  parameter int LIVES         = 3,
  parameter int HIT_HOLD      = 25000000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SW1,
  input  logic                      SW2,
  input  logic                      SW3,
  input  logic                      SW4,
  input  logic [NUM_CARS*10-1:0]    car_x,
  input  logic [NUM_CARS*10-1:0]    car_y,
  input  logic [NUM_CARS-1:0]       car_active,
  output logic [9:0]                rplayer_x,
  output logic [9:0]                rplayer_y,
  output logic [SCORE_DIGITS*4-1:0] score_bcd,
  output logic [SCORE_DIGITS*7-1:0] seg,
  output logic [3:0]                lives,
  output logic                      hit_pulse,
  output logic                      score_pulse,
  output logic                      game_over
);

  localparam logic [1:0] ST_PLAY      = PLAY;
  localparam logic [1:0] ST_HIT       = HIT;
  localparam logic [1:0] ST_GAME_OVER = GAME_OVER;

  localparam int MOVE_W = $clog2(MOVE_PERIOD);
  localparam int HOLD_W = $clog2(HIT_HOLD + 1);

  localparam logic [COORD_W-1:0] SPAWN_X = COORD_W'(H_DISPLAY / 2);
  localparam logic [COORD_W-1:0] SPAWN_Y = COORD_W'(V_DISPLAY - PLAYER_HEIGHT);

  logic [1:0]        state;
  logic              ready;
  logic [MOVE_W-1:0] move_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic [CMP_W-1:0]   px, py;
  logic               hit, goal, move_fire;
  logic [COORD_W-1:0] nx, ny;
  logic               soft_rst, rst;

  assign soft_rst = SW1 & SW2 & SW3 & SW4;
  assign rst      = RST | soft_rst;

  assign px = CMP_W'(rplayer_x);
  assign py = CMP_W'(rplayer_y);

  // Strict box overlap in 11 bits so right/bottom edges near 1023 cannot wrap.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (car_active[i]
          && px < CMP_W'(car_x[10*i +: 10]) + CMP_W'(CAR_WIDTH)
          && CMP_W'(car_x[10*i +: 10]) < px + CMP_W'(PLAYER_WIDTH)
          && py < CMP_W'(car_y[10*i +: 10]) + CMP_W'(CAR_HEIGHT)
          && CMP_W'(car_y[10*i +: 10]) < py + CMP_W'(PLAYER_HEIGHT))
        hit = 1'b1;
    end
    if (state != ST_PLAY) hit = 1'b0;
  end

  assign goal = (state == ST_PLAY) && (rplayer_y == '0) && !hit;

  // The highest-priority pressed switch decides; if it is blocked nothing moves.
  always_comb begin
    move_fire = 1'b0;
    nx        = rplayer_x;
    ny        = rplayer_y;
    if (state == ST_PLAY && ready && !hit && !goal) begin
      if (SW1) begin
        if (py >= CMP_W'(STEP)) begin
          move_fire = 1'b1;
          ny        = rplayer_y - COORD_W'(STEP);
        end
      end else if (SW2) begin
        if (py + CMP_W'(STEP) <= CMP_W'(V_DISPLAY - PLAYER_HEIGHT)) begin
          move_fire = 1'b1;
          ny        = rplayer_y + COORD_W'(STEP);
        end
      end else if (SW3) begin
        if (px >= CMP_W'(STEP)) begin
          move_fire = 1'b1;
          nx        = rplayer_x - COORD_W'(STEP);
        end
      end else if (SW4) begin
        if (px + CMP_W'(STEP) <= CMP_W'(H_DISPLAY - PLAYER_WIDTH)) begin
          move_fire = 1'b1;
          nx        = rplayer_x + COORD_W'(STEP);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      rplayer_x   <= SPAWN_X;
      rplayer_y   <= SPAWN_Y;
      state       <= ST_PLAY;
      ready       <= 1'b1;
      move_cnt    <= '0;
      hold_cnt    <= '0;
      hit_pulse   <= 1'b0;
      score_pulse <= 1'b0;
    end else begin
      hit_pulse   <= 1'b0;
      score_pulse <= 1'b0;

      if (move_fire) begin
        move_cnt <= '0;
        ready    <= 1'b0;
      end else if (move_cnt != MOVE_W'(MOVE_PERIOD - 1)) begin
        move_cnt <= move_cnt + 1'b1;
        if (move_cnt == MOVE_W'(MOVE_PERIOD - 2)) ready <= 1'b1;
      end

      case (state)
        ST_PLAY: begin
          if (hit) begin
            hit_pulse <= 1'b1;
            hold_cnt  <= '0;
            state     <= ST_HIT;
          end else if (goal) begin
            score_pulse <= 1'b1;
            rplayer_x   <= SPAWN_X;
            rplayer_y   <= SPAWN_Y;
          end else if (move_fire) begin
            rplayer_x <= nx;
            rplayer_y <= ny;
          end
        end
        ST_HIT: begin
          if (hold_cnt == HOLD_W'(HIT_HOLD - 1)) begin
            rplayer_x <= SPAWN_X;
            rplayer_y <= SPAWN_Y;
            ready     <= 1'b0;
            move_cnt  <= '0;
`ifdef PLAYER_LIVES_EN
            state     <= (lives == 4'd0) ? ST_GAME_OVER : ST_PLAY;
`else
            state     <= ST_PLAY;
`endif
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GAME_OVER: state <= ST_GAME_OVER;
        default:      state <= ST_PLAY;
      endcase
    end
  end

`ifdef PLAYER_LIVES_EN
  always_ff @(posedge CLK) begin
    if (rst)                     lives <= 4'(LIVES);
    else if (hit && lives != '0) lives <= lives - 4'd1;
  end

  assign game_over = (state == ST_GAME_OVER);

  bcd_score_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_score (
    .clk       (CLK),
    .rst       (rst),
    .inc       (goal),
    .clr       (1'b0),
    .score_bcd (score_bcd)
  );
`else
  assign lives     = 4'd0;
  assign game_over = 1'b0;

  bcd_score_counter #(.SCORE_DIGITS(SCORE_DIGITS)) u_score (
    .clk       (CLK),
    .rst       (rst),
    .inc       (goal),
    .clr       (hit),
    .score_bcd (score_bcd)
  );
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < SCORE_DIGITS; i++) seg[7*i +: 7] <= seg7(4'd0);
    end else begin
      for (int i = 0; i < SCORE_DIGITS; i++) seg[7*i +: 7] <= seg7(score_bcd[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_player_ctrl_multi.sv
// Directed bench for player_ctrl_multi; lives checks adapt to PLAYER_LIVES_EN.
module tb_player_ctrl_multi;

  localparam int NC = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0, SW4 = 1'b0;
  logic [NC*10-1:0] car_x = '0, car_y = '0;
  logic [NC-1:0] car_active = '0;
  logic [9:0]    rplayer_x, rplayer_y;
  logic [7:0]    score_bcd;
  logic [13:0]   seg;
  logic [3:0]    lives;
  logic          hit_pulse, score_pulse, game_over;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PLAYER_LIVES_EN
  localparam logic [3:0] LIVES_RST       = 4'd3;
  localparam logic [3:0] LIVES_AFTER_HIT = 4'd2;
  localparam logic [7:0] SCORE_AFTER_HIT = 8'h01;
`else
  localparam logic [3:0] LIVES_RST       = 4'd0;
  localparam logic [3:0] LIVES_AFTER_HIT = 4'd0;
  localparam logic [7:0] SCORE_AFTER_HIT = 8'h00;
`endif

  player_ctrl_multi #(
    .H_DISPLAY(640), .V_DISPLAY(480), .PLAYER_WIDTH(32), .PLAYER_HEIGHT(32),
    .STEP(32), .MOVE_PERIOD(4), .NUM_CARS(NC), .CAR_WIDTH(64), .CAR_HEIGHT(32),
    .SCORE_DIGITS(2), .LIVES(3), .HIT_HOLD(3)
  ) dut (
    .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .car_x(car_x), .car_y(car_y), .car_active(car_active),
    .rplayer_x(rplayer_x), .rplayer_y(rplayer_y),
    .score_bcd(score_bcd), .seg(seg), .lives(lives),
    .hit_pulse(hit_pulse), .score_pulse(score_pulse), .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_sw(input logic [3:0] sw);
    {SW4, SW3, SW2, SW1} = sw;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset;
    set_sw(4'b0000);
    car_active = '0;
    @(negedge CLK);
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
  endtask

  task automatic wait_goals(input int target, inout int got);
    int budget;
    budget = 60 * (target - got) + 100;
    while (got < target && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (score_pulse) got++;
    end
    n_cmp++;
    if (got != target) begin
      n_bad++;
      $display("FAIL goal_wait: got %0d goals want %0d", got, target);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (rplayer_x !== 10'd320) begin n_bad++; $display("FAIL rst_x: got %0d want 320", rplayer_x); end
    n_cmp++; if (rplayer_y !== 10'd448) begin n_bad++; $display("FAIL rst_y: got %0d want 448", rplayer_y); end
    n_cmp++; if (score_bcd !== 8'h00) begin n_bad++; $display("FAIL rst_score: got %h want 00", score_bcd); end
    n_cmp++; if (seg !== 14'b0000001_0000001) begin n_bad++; $display("FAIL rst_seg: got %b want 00000010000001", seg); end
    n_cmp++; if (lives !== LIVES_RST) begin n_bad++; $display("FAIL rst_lives: got %0d want %0d", lives, LIVES_RST); end
    n_cmp++; if ({hit_pulse, score_pulse, game_over} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {hit_pulse, score_pulse, game_over}); end
  endtask

  task automatic test_move_up;
    do_reset();
    set_sw(4'b0001);
    for (int k = 1; k <= 12; k++) begin
      cycles(1);
      if (k == 1) begin
        n_cmp++; if (rplayer_y !== 10'd416) begin n_bad++; $display("FAIL move_first: got %0d want 416", rplayer_y); end
      end else if (k == 4) begin
        n_cmp++; if (rplayer_y !== 10'd416) begin n_bad++; $display("FAIL move_rate: got %0d want 416", rplayer_y); end
      end else if (k == 5) begin
        n_cmp++; if (rplayer_y !== 10'd384) begin n_bad++; $display("FAIL move_second: got %0d want 384", rplayer_y); end
      end else if (k == 12) begin
        n_cmp++; if (rplayer_y !== 10'd352) begin n_bad++; $display("FAIL move_third: got %0d want 352", rplayer_y); end
      end
    end
    set_sw(4'b0000);
  endtask

  task automatic test_priority_block;
    set_sw(4'b0100);
    cycles(40);
    n_cmp++; if (rplayer_x !== 10'd0) begin n_bad++; $display("FAIL left_edge: got %0d want 0", rplayer_x); end
    set_sw(4'b1100);
    cycles(8);
    n_cmp++; if (rplayer_x !== 10'd0) begin n_bad++; $display("FAIL blocked_left: got %0d want 0", rplayer_x); end
    set_sw(4'b1000);
    cycles(1);
    n_cmp++; if (rplayer_x !== 10'd32) begin n_bad++; $display("FAIL ready_kept: got %0d want 32", rplayer_x); end
    set_sw(4'b0000);
  endtask

  task automatic test_hit;
    int  k;
    bit  seen;
    do_reset();
    set_sw(4'b0001);
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      cycles(1);
      k++;
      if (score_pulse) seen = 1'b1;
    end
    set_sw(4'b0000);
    n_cmp++; if (!seen || k != 54) begin n_bad++; $display("FAIL first_goal_cycle: got %0d (seen %0d) want 54", k, seen); end
    n_cmp++; if (score_bcd !== 8'h01) begin n_bad++; $display("FAIL first_goal_score: got %h want 01", score_bcd); end
    n_cmp++; if (rplayer_y !== 10'd448) begin n_bad++; $display("FAIL goal_respawn: got %0d want 448", rplayer_y); end
    car_x = {10'd0, 10'd320};
    car_y = {10'd0, 10'd416};
    car_active = 2'b01;
    cycles(4);
    set_sw(4'b0001);
    cycles(1);
    n_cmp++; if (rplayer_y !== 10'd416 || hit_pulse !== 1'b0) begin n_bad++; $display("FAIL hit_step: y=%0d hit=%b want 416/0", rplayer_y, hit_pulse); end
    set_sw(4'b0100);
    cycles(1);
    n_cmp++; if (hit_pulse !== 1'b1) begin n_bad++; $display("FAIL hit_pulse: got %b want 1", hit_pulse); end
    n_cmp++; if (lives !== LIVES_AFTER_HIT) begin n_bad++; $display("FAIL hit_lives: got %0d want %0d", lives, LIVES_AFTER_HIT); end
    n_cmp++; if (score_bcd !== SCORE_AFTER_HIT) begin n_bad++; $display("FAIL hit_score: got %h want %h", score_bcd, SCORE_AFTER_HIT); end
    cycles(1);
    n_cmp++; if (hit_pulse !== 1'b0) begin n_bad++; $display("FAIL hit_one_cycle: got %b want 0", hit_pulse); end
    cycles(1);
    n_cmp++; if (rplayer_x !== 10'd320 || rplayer_y !== 10'd416) begin n_bad++; $display("FAIL hit_frozen: got (%0d,%0d) want (320,416)", rplayer_x, rplayer_y); end
    cycles(1);
    n_cmp++; if (rplayer_x !== 10'd320 || rplayer_y !== 10'd448) begin n_bad++; $display("FAIL hit_respawn: got (%0d,%0d) want (320,448)", rplayer_x, rplayer_y); end
    set_sw(4'b0000);
    car_active = '0;
  endtask

  task automatic test_inactive_car;
    do_reset();
    car_x = {10'd0, 10'd320};
    car_y = {10'd0, 10'd416};
    car_active = 2'b00;
    set_sw(4'b0001);
    cycles(1);
    set_sw(4'b0000);
    for (int k = 0; k < 3; k++) begin
      cycles(1);
      n_cmp++; if (hit_pulse !== 1'b0) begin n_bad++; $display("FAIL inactive_no_hit: got %b want 0 (cycle %0d)", hit_pulse, k); end
    end
    car_x = {10'd320, 10'd0};
    car_y = {10'd416, 10'd0};
    car_active = 2'b10;
    cycles(1);
    n_cmp++; if (hit_pulse !== 1'b1) begin n_bad++; $display("FAIL car1_hit: got %b want 1", hit_pulse); end
    car_active = '0;
  endtask

  task automatic test_score;
    int got;
    do_reset();
    got = 0;
    set_sw(4'b0001);
    wait_goals(10, got);
    n_cmp++; if (score_bcd !== 8'h10) begin n_bad++; $display("FAIL score_10: got %h want 10", score_bcd); end
    cycles(1);
    n_cmp++; if (seg !== {7'b1001111, 7'b0000001}) begin n_bad++; $display("FAIL seg_10: got %b want 10011110000001", seg); end
    wait_goals(99, got);
    n_cmp++; if (score_bcd !== 8'h99) begin n_bad++; $display("FAIL score_99: got %h want 99", score_bcd); end
    wait_goals(100, got);
    n_cmp++; if (score_bcd !== 8'h99) begin n_bad++; $display("FAIL score_sat: got %h want 99", score_bcd); end
    cycles(1);
    n_cmp++; if (seg !== {7'b0000100, 7'b0000100}) begin n_bad++; $display("FAIL seg_99: got %b want 00001000000100", seg); end
    set_sw(4'b0000);
  endtask

  task automatic test_soft_reset;
    set_sw(4'b0001);
    cycles(5);
    set_sw(4'b1111);
    cycles(1);
    set_sw(4'b0000);
    n_cmp++; if (score_bcd !== 8'h00) begin n_bad++; $display("FAIL soft_score: got %h want 00", score_bcd); end
    n_cmp++; if (seg !== 14'b0000001_0000001) begin n_bad++; $display("FAIL soft_seg: got %b want 00000010000001", seg); end
    n_cmp++; if (rplayer_x !== 10'd320 || rplayer_y !== 10'd448) begin n_bad++; $display("FAIL soft_pos: got (%0d,%0d) want (320,448)", rplayer_x, rplayer_y); end
    n_cmp++; if (lives !== LIVES_RST) begin n_bad++; $display("FAIL soft_lives: got %0d want %0d", lives, LIVES_RST); end
  endtask

`ifdef PLAYER_LIVES_EN
  task automatic test_game_over;
    int got;
    int hits;
    int budget;
    do_reset();
    got = 0;
    set_sw(4'b0001);
    wait_goals(1, got);
    set_sw(4'b0000);
    car_x = {10'd0, 10'd320};
    car_y = {10'd0, 10'd416};
    car_active = 2'b01;
    set_sw(4'b0001);
    hits = 0; budget = 200;
    while (hits < 3 && budget > 0) begin
      cycles(1);
      budget--;
      if (hit_pulse) hits++;
    end
    set_sw(4'b0000);
    n_cmp++; if (hits != 3) begin n_bad++; $display("FAIL go_hits: got %0d want 3", hits); end
    cycles(5);
    n_cmp++; if (game_over !== 1'b1 || lives !== 4'd0) begin n_bad++; $display("FAIL go_flag: game_over=%b lives=%0d want 1/0", game_over, lives); end
    n_cmp++; if (score_bcd !== 8'h01) begin n_bad++; $display("FAIL go_score_kept: got %h want 01", score_bcd); end
    set_sw(4'b0001);
    cycles(8);
    set_sw(4'b0000);
    n_cmp++; if (rplayer_x !== 10'd320 || rplayer_y !== 10'd448 || game_over !== 1'b1) begin n_bad++; $display("FAIL go_frozen: got (%0d,%0d) go=%b want (320,448) 1", rplayer_x, rplayer_y, game_over); end
    set_sw(4'b1111);
    cycles(1);
    set_sw(4'b0000);
    car_active = '0;
    n_cmp++; if (score_bcd !== 8'h00 || lives !== 4'd3 || game_over !== 1'b0) begin n_bad++; $display("FAIL go_soft_reset: score=%h lives=%0d go=%b want 00/3/0", score_bcd, lives, game_over); end
    set_sw(4'b0001);
    cycles(1);
    set_sw(4'b0000);
    n_cmp++; if (rplayer_y !== 10'd416) begin n_bad++; $display("FAIL go_play_again: got %0d want 416", rplayer_y); end
  endtask
`endif

  initial begin
    test_reset();
    test_move_up();
    test_priority_block();
    test_hit();
    test_inactive_car();
    test_score();
    test_soft_reset();
`ifdef PLAYER_LIVES_EN
    test_game_over();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
